// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (same encoding as the memory bitWid port)
//   - FSM state encoding for lsu_mem_master
//   - size_bytes(): number of bytes touched by an access size
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // Illegal size reports 0 bytes; the checker rejects it on size alone.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_WORD: size_bytes = 3'd4;
      SZ_HALF: size_bytes = 3'd2;
      SZ_BYTE: size_bytes = 3'd1;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_access_check.sv
// lsu_access_check: combinational legality check of a memory access.
// Ports:
//   size_i [1:0]  access size (SZ_* encoding)
//   addr_i [31:0] byte address
//   err_o         1 = illegal size, misaligned, or beyond MEM_BYTES
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  logic [32:0] end_s;
  logic        misalign_s;
  logic        range_s;

  // Alignment and range classification; the end address is formed in 33 bits
  // so an access near 0xFFFF_FFFF cannot wrap back into range.
  always_comb begin
    end_s   = {1'b0, addr_i} + {30'd0, size_bytes(size_i)};
    range_s = (end_s > 33'(MEM_BYTES));
    case (size_i)
      SZ_WORD: misalign_s = (addr_i[1:0] != 2'b00);
      SZ_HALF: misalign_s = addr_i[0];
      SZ_BYTE: misalign_s = 1'b0;
      default: misalign_s = 1'b1;
    endcase
    err_o = misalign_s | range_s;
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core and the big-endian
// byte-addressed data memory. One request at a time.
// Ports:
//   CLK, Reset (async active-low)
//   req_*   : core request channel (valid/ready), req_ready high only in IDLE
//   resp_*  : response channel (valid/ready), data held until accepted
//   err_count: saturating count of rejected requests
//   mRD, mWR, sign, bitWid, DAddr, DataIn: registered memory port
//   DataOut : combinational read data from memory
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ERRW      = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_sign,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic [ERRW-1:0] err_count,
  output logic            mRD,
  output logic            mWR,
  output logic            sign,
  output logic [1:0]      bitWid,
  output logic [31:0]     DAddr,
  output logic [31:0]     DataIn,
  input  logic [31:0]     DataOut
);

  lsu_state_e      state_q;
  logic            mrd_q, mwr_q, sign_q;
  logic [1:0]      bitwid_q;
  logic [31:0]     daddr_q, datain_q;
  logic            resp_valid_q, resp_err_q;
  logic [31:0]     resp_rdata_q;
  logic [ERRW-1:0] err_count_q, err_count_d;
  logic            chk_err_s;

  lsu_access_check #(.MEM_BYTES(MEM_BYTES)) u_check (
    .size_i (req_size),
    .addr_i (req_addr),
    .err_o  (chk_err_s)
  );

  // Saturating increment of the reject counter.
  always_comb begin
    if (&err_count_q) begin
      err_count_d = err_count_q;
    end else begin
      err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM with all memory-side and response outputs registered.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      mrd_q        <= 1'b0;
      mwr_q        <= 1'b0;
      sign_q       <= 1'b0;
      bitwid_q     <= 2'b00;
      daddr_q      <= 32'd0;
      datain_q     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      err_count_q  <= {ERRW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (chk_err_s) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
              err_count_q  <= err_count_d;
              state_q      <= ST_RESP;
            end else begin
              daddr_q  <= req_addr;
              bitwid_q <= req_size;
              sign_q   <= req_sign;
              datain_q <= req_wdata;
              mrd_q    <= ~req_we;
              mwr_q    <= req_we;
              state_q  <= ST_ACCESS;
            end
          end
        end
        // Single access cycle: memory writes on the negedge in here, and
        // read data is sampled from DataOut at the closing posedge.
        ST_ACCESS: begin
          mrd_q        <= 1'b0;
          mwr_q        <= 1'b0;
          resp_rdata_q <= mrd_q ? DataOut : 32'd0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          mrd_q        <= 1'b0;
          mwr_q        <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign err_count  = err_count_q;
  assign mRD        = mrd_q;
  assign mWR        = mwr_q;
  assign sign       = sign_q;
  assign bitWid     = bitwid_q;
  assign DAddr      = daddr_q;
  assign DataIn     = datain_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master with a big-endian 128-byte memory model.
module tb_lsu_mem_master;

  localparam int MEMB = 128;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  err_count;
  logic        mRD, mWR, sign;
  logic [1:0]  bitWid;
  logic [31:0] DAddr, DataIn, DataOut;

  always #5 CLK = ~CLK;

  lsu_mem_master #(.MEM_BYTES(128), .ERRW(8)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .err_count(err_count),
    .mRD(mRD), .mWR(mWR), .sign(sign), .bitWid(bitWid),
    .DAddr(DAddr), .DataIn(DataIn), .DataOut(DataOut)
  );

  // Memory model: combinational big-endian read, write on negedge.
  logic [7:0] mem     [0:MEMB-1];
  logic [7:0] ref_mem [0:MEMB-1];
  logic [6:0] ra;
  int         rd_total = 0;
  int         wr_total = 0;

  assign ra = DAddr[6:0];

  always_comb begin
    case (bitWid)
      2'b00: DataOut = {mem[ra], mem[ra+7'd1], mem[ra+7'd2], mem[ra+7'd3]};
      2'b01: DataOut = {(sign ? {16{mem[ra][7]}} : 16'd0), mem[ra], mem[ra+7'd1]};
      2'b10: DataOut = {(sign ? {24{mem[ra][7]}} : 24'd0), mem[ra]};
      default: DataOut = 32'd0;
    endcase
  end

  always @(negedge CLK) begin
    if (mRD) rd_total++;
    if (mWR) begin
      wr_total++;
      case (bitWid)
        2'b00: begin
          mem[ra] <= DataIn[31:24]; mem[ra+7'd1] <= DataIn[23:16];
          mem[ra+7'd2] <= DataIn[15:8]; mem[ra+7'd3] <= DataIn[7:0];
        end
        2'b01: begin mem[ra] <= DataIn[15:8]; mem[ra+7'd1] <= DataIn[7:0]; end
        2'b10: mem[ra] <= DataIn[7:0];
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned nb;
    nb = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    if (size == 2'b11) return 1'b1;
    if ((addr % nb) != 0) return 1'b1;
    if (longint'(addr) + nb > MEMB) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int a;
    a = int'(addr);
    case (size)
      2'b00: return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
      2'b01: return sgn ? {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]}
                        : {16'd0, ref_mem[a], ref_mem[a+1]};
      default: return sgn ? {{24{ref_mem[a][7]}}, ref_mem[a]} : {24'd0, ref_mem[a]};
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    a = int'(addr);
    case (size)
      2'b00: begin
        ref_mem[a] = wd[31:24]; ref_mem[a+1] = wd[23:16];
        ref_mem[a+2] = wd[15:8]; ref_mem[a+3] = wd[7:0];
      end
      2'b01: begin ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0]; end
      default: ref_mem[a] = wd[7:0];
    endcase
  endtask

  // Drive one request, wait for its response and compare against the scoreboard.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] exp_rd);
    exp_t e;
    int   rd0, wr0, lat;
    logic er;
    er      = ref_err(size, addr);
    e.err   = er;
    e.lat   = er ? 1 : 2;
    e.rdata = (er || we) ? 32'd0 : ref_load(size, sgn, addr);
    if (!er && we) ref_store(size, addr, wd);
    if (er) exp_errs++;
    sb_q.push_back(e);
    rd0 = rd_total;
    wr0 = wr_total;
    @(negedge CLK);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_sign = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (!er) begin
      chk("access_daddr", DAddr, addr);
      chk("access_bitwid", {30'd0, bitWid}, {30'd0, size});
      chk("access_mwr", {31'd0, mWR}, {31'd0, we});
      chk("access_mrd", {31'd0, mRD}, {31'd0, ~we});
    end
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk("resp_latency", 32'(lat), 32'(e.lat));
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
    chk("err_count", {24'd0, err_count}, 32'(exp_errs));
    chk("rd_pulses", 32'(rd_total - rd0), (!er && !we) ? 32'd1 : 32'd0);
    chk("wr_pulses", 32'(wr_total - wr0), (!er && we) ? 32'd1 : 32'd0);
    exp_rd = e.rdata;
  endtask

  task automatic take_resp();
    @(negedge CLK);
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    chk("resp_valid_clr", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] x;
  int          wr0;

  initial begin
    for (int i = 0; i < MEMB; i++) begin
      mem[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    ref_mem[4] = 8'h11; ref_mem[5] = 8'h22; ref_mem[6] = 8'h33; ref_mem[7] = 8'h44;
    mem[126] = 8'hA5; mem[127] = 8'h5A; ref_mem[126] = 8'hA5; ref_mem[127] = 8'h5A;

    Reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mrd_mwr", {30'd0, mRD, mWR}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_daddr", DAddr, 32'd0);
    chk("rst_datain", DataIn, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1;

    // Word load and byte store / signed and unsigned byte loads
    send(1'b0, 2'b00, 1'b0, 32'h4, 32'd0, x); take_resp();
    send(1'b1, 2'b10, 1'b0, 32'h5, 32'h0000_00AB, x); take_resp();
    send(1'b0, 2'b10, 1'b1, 32'h5, 32'd0, x); take_resp();
    send(1'b0, 2'b10, 1'b0, 32'h5, 32'd0, x); take_resp();
    send(1'b0, 2'b00, 1'b0, 32'h4, 32'd0, x); take_resp();
    chk("word_after_byte_store", x, 32'h11AB_3344);

    // Rejected: misaligned word, misaligned half store, out of range, bad size
    send(1'b0, 2'b00, 1'b0, 32'h2, 32'd0, x); take_resp();
    send(1'b1, 2'b01, 1'b0, 32'h7, 32'h1234, x); take_resp();
    chk("err_count_two", {24'd0, err_count}, 32'd2);
    send(1'b0, 2'b00, 1'b0, 32'h7E, 32'd0, x); take_resp();
    send(1'b0, 2'b11, 1'b0, 32'h0, 32'd0, x); take_resp();
    send(1'b0, 2'b01, 1'b0, 32'h7E, 32'd0, x); take_resp();
    send(1'b0, 2'b01, 1'b1, 32'h7E, 32'd0, x); take_resp();
    send(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd0, x); take_resp();

    // Backpressure: response held while a second request is pending
    send(1'b0, 2'b00, 1'b0, 32'h4, 32'd0, x);
    wr0 = wr_total;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'hCAFE_F00D;
      req_valid = 1'b1;
      @(posedge CLK); #1;
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, x);
      chk("bp_err", {31'd0, resp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge CLK);
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("bp_release", {31'd0, resp_valid}, 32'd0);
    chk("bp_no_accept", {30'd0, mRD, mWR}, 32'd0);
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    chk("bp_no_write", 32'(wr_total - wr0), 32'd0);
    chk("bp_mem0", {mem[0], mem[1], mem[2], mem[3]},
        {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]});

    // Reset during ACCESS of a word store, before the negedge
    wr0 = wr_total;
    req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h8;
    req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("rst_mid_mwr_before", {31'd0, mWR}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    exp_errs = 0;
    chk("rst_mid_mwr", {30'd0, mRD, mWR}, 32'd0);
    chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_daddr", DAddr, 32'd0);
    chk("rst_mid_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    #2 Reset = 1'b1;
    chk("rst_mid_no_write", 32'(wr_total - wr0), 32'd0);
    chk("rst_mid_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h0809_0A0B);
    send(1'b0, 2'b00, 1'b0, 32'h8, 32'd0, x); take_resp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the CPU core and the byte-addressed, big-endian data memory.
- Takes one request at a time from the core over a valid/ready handshake.
- Checks size, alignment and range, then drives the memory port (mRD, mWR, sign, bitWid, DAddr, DataIn) for exactly one access cycle.
- Captures read data and returns a response with valid/ready backpressure.

Parameters:
- MEM_BYTES, 128, size of data memory in bytes; any access with addr+size > MEM_BYTES is an error.
- ERRW, 8, width of the saturating error counter.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 half, 10 byte, 11 illegal.
- req_sign  input  1  sign-extend a load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response available.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  32  load data, already extended by memory; 0 for stores and errors.
- resp_err  output  1  access rejected: illegal size, misaligned or out of range.
- err_count  output  ERRW  saturating count of rejected requests.
- mRD  output  1  memory read enable.
- mWR  output  1  memory write enable; memory writes on negedge CLK.
- sign  output  1  to memory.
- bitWid  output  2  to memory, same encoding as req_size.
- DAddr  output  32  memory byte address.
- DataIn  output  32  memory write data.
- DataOut  input  32  memory read data, combinational from memory.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - mRD=mWR=0, sign=0, bitWid=00, DAddr=0, DataIn=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, err_count=0.
  - req_ready is combinational from state, so it is 1 during reset.
- All memory-side outputs are registered; no combinational path from req_* to the memory port.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1, the request is accepted and classified.
- Classification:
  - err when req_size==11.
  - err when word and addr[1:0]!=0.
  - err when half and addr[0]!=0.
  - err when addr+bytes > MEM_BYTES, using 33-bit compare so wrap-around never passes.
- Legal request at the accept edge:
  - load DAddr=req_addr, bitWid=req_size, sign=req_sign, DataIn=req_wdata.
  - set mRD=~req_we, mWR=req_we.
  - go to ACCESS.
- Illegal request at the accept edge:
  - mRD and mWR stay 0.
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - err_count increments, holding at all-ones.
  - go to RESP.
- ACCESS (exactly one cycle):
  - Memory performs the write on the negedge inside this cycle.
  - At the next posedge: mRD=mWR=0, resp_rdata=DataOut for loads (0 for stores), resp_err=0, resp_valid=1, go to RESP.
  - DAddr, bitWid, sign and DataIn hold their values through ACCESS and keep them afterwards.
- RESP:
  - resp_valid and the data are held stable until resp_ready=1 at a posedge.
  - On that edge resp_valid clears and the unit returns to IDLE.
  - A new request cannot be accepted on that same edge; req_ready is 0 in RESP.
- Latency:
  - legal request: accept edge to resp_valid is 2 edges.
  - illegal request: 1 edge.
  - minimum throughput is one request per 3 cycles.
- mWR is high for exactly one full clock period per store, which guarantees exactly one negedge write.
- Reset mid-ACCESS: mWR drops immediately. If Reset falls before the negedge, no write occurs. A response in flight is discarded.
- req_valid low or req_* changing outside the accept edge has no effect.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_BAD=2'b11.
  - state encoding for IDLE/ACCESS/RESP.
  - function size_bytes(size) returning 4/2/1.
- One sub-module: lsu_access_check, purely combinational (size, addr -> err). It is reused later by the instruction-fetch path.

Test Plan:
- Word load at 0x4, memory bytes 4..7 = 11 22 33 44, req_sign=0 -> mRD=1 for one cycle with DAddr=0x4, bitWid=00; resp_rdata=0x11223344, resp_err=0; resp_valid on the 2nd edge after accept.
- Byte store 0x000000AB at 0x5, then signed byte load at 0x5 -> mWR high exactly one cycle; byte 5 = 0xAB, bytes 4/6/7 unchanged; load returns 0xFFFFFFAB; unsigned load returns 0x000000AB.
- Misaligned word load at 0x2, then half store at 0x7 -> mRD and mWR never assert; resp_err=1, resp_rdata=0, 1-edge latency; err_count=2.
- Out-of-range word at 0x7E and illegal size 11 at 0x0 (MEM_BYTES=128) -> both resp_err=1; half at 0x7E is legal and reads bytes 126..127.
- Backpressure: resp_ready held 0 for 4 cycles -> resp_valid, resp_rdata and resp_err stable, req_ready=0, a second request is not accepted; the response completes on the first edge with resp_ready=1.
- Reset pulse asserted during ACCESS of a word store to 0x8, before the negedge -> outputs clear at once, memory bytes 8..11 unchanged, state IDLE, err_count=0.
